// File: rtl/pipe_ctl_pkg.sv
// Shared definitions for the pipeline stall/flush control slice.
//   state_t    : sequencer state encoding (RUN, DMISS, IMISS, ERR)
//   CNT_W_DEF  : default width of the miss-wait counter
package pipe_ctl_pkg;

    localparam int unsigned CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DMISS = 2'd1,
        ST_IMISS = 2'd2,
        ST_ERR   = 2'd3
    } state_t;

endpackage

// File: rtl/pipe_load_use.sv
// Combinational load-use hazard detector.
// Flags a hazard when the load in ID/EX writes a register (other than r0)
// that the instruction in IF/ID reads as rs or rt.
//   i_idex_memread : ID/EX holds a load
//   i_idex_rt      : load destination register
//   i_ifid_rs      : rs of the IF/ID instruction
//   i_ifid_rt      : rt of the IF/ID instruction
//   o_hazard       : one bubble must be inserted this cycle
module pipe_load_use (
    input  logic       i_idex_memread,
    input  logic [4:0] i_idex_rt,
    input  logic [4:0] i_ifid_rs,
    input  logic [4:0] i_ifid_rt,
    output logic       o_hazard
);

    assign o_hazard = i_idex_memread && (i_idex_rt != 5'd0) &&
                      ((i_idex_rt == i_ifid_rs) || (i_idex_rt == i_ifid_rt));

endmodule

// File: rtl/pipe_stall_ctl.sv
// Stall/flush sequencer for the 5-stage pipeline. Produces per-stage capture
// enables and bubble controls from cache-hit, load-use and branch inputs, and
// waits out I-cache/D-cache misses under a timeout watchdog.
// Outputs are combinational from state and inputs: they settle after posedge
// and are sampled by the pipeline registers at negedge.
//
// Ports:
//   clk, rstn                      clock, async active-low reset
//   i_icache_hit / i_dcache_hit    cache hit indications
//   i_dmem_access                  EX/MEM holds a load or store
//   i_idex_memread, i_idex_rt      load in ID/EX and its destination
//   i_ifid_rs, i_ifid_rt           source registers of IF/ID instruction
//   i_branch_taken                 branch resolved taken in MEM
//   o_*_en                         stage capture enables
//   o_*_flush                      bubble insertion controls
//   o_state, o_err                 current state, sticky timeout flag
// Optional macro PIPE_STALL_PERF_EN adds o_perf_dmiss, o_perf_imiss and
// o_perf_lu stall-cycle counters (32-bit, wrapping).
//
// state | meaning
// RUN   | normal issue; load-use bubbles and branch flushes handled here
// DMISS | waiting for D-cache, whole pipeline frozen
// IMISS | waiting for I-cache, bubbles fed into IF/ID, older stages drain
// ERR   | a miss exceeded MISS_TIMEOUT; frozen until reset
module pipe_stall_ctl
    import pipe_ctl_pkg::*;
#(
    parameter int unsigned MISS_TIMEOUT = 255,
    parameter int unsigned CNT_W        = CNT_W_DEF
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       i_icache_hit,
    input  logic       i_dcache_hit,
    input  logic       i_dmem_access,
    input  logic       i_idex_memread,
    input  logic [4:0] i_idex_rt,
    input  logic [4:0] i_ifid_rs,
    input  logic [4:0] i_ifid_rt,
    input  logic       i_branch_taken,
    output logic       o_pc_en,
    output logic       o_ifid_en,
    output logic       o_idex_en,
    output logic       o_exmem_en,
    output logic       o_memwb_en,
    output logic       o_ifid_flush,
    output logic       o_idex_flush,
    output logic       o_exmem_flush,
    output logic [1:0] o_state,
    output logic       o_err
`ifdef PIPE_STALL_PERF_EN
    ,
    output logic [31:0] o_perf_dmiss,
    output logic [31:0] o_perf_imiss,
    output logic [31:0] o_perf_lu
`endif
);

    localparam logic [CNT_W-1:0] TMO_M1  = CNT_W'(MISS_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_sat;
    logic             lu_hazard;
    logic             dmiss;

    pipe_load_use u_load_use (
        .i_idex_memread (i_idex_memread),
        .i_idex_rt      (i_idex_rt),
        .i_ifid_rs      (i_ifid_rs),
        .i_ifid_rt      (i_ifid_rt),
        .o_hazard       (lu_hazard)
    );

    assign dmiss   = i_dmem_access && !i_dcache_hit;
    assign cnt_sat = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        o_pc_en       = 1'b1;
        o_ifid_en     = 1'b1;
        o_idex_en     = 1'b1;
        o_exmem_en    = 1'b1;
        o_memwb_en    = 1'b1;
        o_ifid_flush  = 1'b0;
        o_idex_flush  = 1'b0;
        o_exmem_flush = 1'b0;

        unique case (state_q)
            ST_RUN, ST_IMISS: begin
                if (dmiss) begin
                    {o_pc_en, o_ifid_en, o_idex_en, o_exmem_en, o_memwb_en} = 5'b0;
                    state_d = ST_DMISS;
                    cnt_d   = '0;
                end else if (i_branch_taken) begin
                    // Taken branch abandons any pending I-miss.
                    {o_ifid_flush, o_idex_flush, o_exmem_flush} = 3'b111;
                    state_d = ST_RUN;
                end else if (!i_icache_hit) begin
                    o_pc_en      = 1'b0;
                    o_ifid_flush = 1'b1;
                    if (state_q == ST_RUN) begin
                        state_d = ST_IMISS;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_sat;
                        if (cnt_q >= TMO_M1) state_d = ST_ERR;
                    end
                end else if (lu_hazard) begin
                    o_pc_en      = 1'b0;
                    o_ifid_en    = 1'b0;
                    o_idex_flush = 1'b1;
                    state_d      = ST_RUN;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DMISS: begin
                if (i_dcache_hit) begin
                    // A branch held behind the miss resolves on the release cycle.
                    if (i_branch_taken) begin
                        {o_ifid_flush, o_idex_flush, o_exmem_flush} = 3'b111;
                    end
                    state_d = ST_RUN;
                end else begin
                    {o_pc_en, o_ifid_en, o_idex_en, o_exmem_en, o_memwb_en} = 5'b0;
                    cnt_d = cnt_sat;
                    if (cnt_q >= TMO_M1) state_d = ST_ERR;
                end
            end
            ST_ERR: begin
                {o_pc_en, o_ifid_en, o_idex_en, o_exmem_en, o_memwb_en} = 5'b0;
            end
        endcase

        // Pipeline frozen while reset is held.
        if (!rstn) begin
            {o_pc_en, o_ifid_en, o_idex_en, o_exmem_en, o_memwb_en} = 5'b0;
            {o_ifid_flush, o_idex_flush, o_exmem_flush}             = 3'b0;
        end
    end

    assign o_state = state_q;
    assign o_err   = (state_q == ST_ERR);

`ifdef PIPE_STALL_PERF_EN
    logic [31:0] perf_dmiss_q, perf_imiss_q, perf_lu_q;
    logic        dmiss_cyc, imiss_cyc, lu_cyc;

    // Stall kinds are recognised from the control pattern they produce.
    assign dmiss_cyc = (state_q != ST_ERR) && !o_pc_en && !o_memwb_en;
    assign imiss_cyc = o_ifid_flush && !o_pc_en;
    assign lu_cyc    = o_idex_flush && !o_ifid_en;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            perf_dmiss_q <= '0;
            perf_imiss_q <= '0;
            perf_lu_q    <= '0;
        end else begin
            if (dmiss_cyc) perf_dmiss_q <= perf_dmiss_q + 32'd1;
            if (imiss_cyc) perf_imiss_q <= perf_imiss_q + 32'd1;
            if (lu_cyc)    perf_lu_q    <= perf_lu_q + 32'd1;
        end
    end

    assign o_perf_dmiss = perf_dmiss_q;
    assign o_perf_imiss = perf_imiss_q;
    assign o_perf_lu    = perf_lu_q;
`endif

endmodule

// File: tb/tb_pipe_stall_ctl.sv
module tb_pipe_stall_ctl;

    logic       clk = 1'b0;
    logic       rstn;
    logic       icache_hit, dcache_hit, dmem_access, idex_memread, branch_taken;
    logic [4:0] idex_rt, ifid_rs, ifid_rt;
    logic       pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic       ifid_flush, idex_flush, exmem_flush;
    logic [1:0] state;
    logic       err;
`ifdef PIPE_STALL_PERF_EN
    logic [31:0] perf_dmiss, perf_imiss, perf_lu;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pipe_stall_ctl #(.MISS_TIMEOUT(4), .CNT_W(8)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .i_icache_hit   (icache_hit),
        .i_dcache_hit   (dcache_hit),
        .i_dmem_access  (dmem_access),
        .i_idex_memread (idex_memread),
        .i_idex_rt      (idex_rt),
        .i_ifid_rs      (ifid_rs),
        .i_ifid_rt      (ifid_rt),
        .i_branch_taken (branch_taken),
        .o_pc_en        (pc_en),
        .o_ifid_en      (ifid_en),
        .o_idex_en      (idex_en),
        .o_exmem_en     (exmem_en),
        .o_memwb_en     (memwb_en),
        .o_ifid_flush   (ifid_flush),
        .o_idex_flush   (idex_flush),
        .o_exmem_flush  (exmem_flush),
        .o_state        (state),
        .o_err          (err)
`ifdef PIPE_STALL_PERF_EN
        ,
        .o_perf_dmiss   (perf_dmiss),
        .o_perf_imiss   (perf_imiss),
        .o_perf_lu      (perf_lu)
`endif
    );

    // en = {pc, ifid, idex, exmem, memwb}; fl = {ifid, idex, exmem}
    typedef struct packed {
        logic       ih, dh, da, mr;
        logic [4:0] idrt, rs, rt;
        logic       br;
        logic [4:0] en;
        logic [2:0] fl;
        logic [1:0] st;
    } vec_t;

    localparam int NV = 24;
    vec_t tbl [NV];

    function automatic vec_t mk(logic ih, logic dh, logic da, logic mr,
                                logic [4:0] idrt, logic [4:0] rs, logic [4:0] rt,
                                logic br, logic [4:0] en, logic [2:0] fl,
                                logic [1:0] st);
        vec_t v;
        v.ih = ih; v.dh = dh; v.da = da; v.mr = mr;
        v.idrt = idrt; v.rs = rs; v.rt = rt; v.br = br;
        v.en = en; v.fl = fl; v.st = st;
        return v;
    endfunction

    task automatic drive(input logic ih, input logic dh, input logic da,
                         input logic mr, input logic [4:0] idrt,
                         input logic [4:0] rs, input logic [4:0] rt,
                         input logic br);
        icache_hit   = ih;
        dcache_hit   = dh;
        dmem_access  = da;
        idex_memread = mr;
        idex_rt      = idrt;
        ifid_rs      = rs;
        ifid_rt      = rt;
        branch_taken = br;
    endtask

    task automatic drive_normal();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    endtask

    task automatic chk(input string name, input logic [4:0] en,
                       input logic [2:0] fl, input logic [1:0] st,
                       input logic er);
        logic [10:0] act, exp;
        act = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush, state, err};
        exp = {en, fl, st, er};
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got en=%b fl=%b st=%0d err=%b, want en=%b fl=%b st=%0d err=%b",
                     name, act[10:6], act[5:3], act[2:1], act[0], en, fl, st, er);
        end
    endtask

    // Apply inputs at negedge (after the posedge state update), check 2 units later.
    task automatic cyc_chk(input string name, input logic [4:0] en,
                           input logic [2:0] fl, input logic [1:0] st,
                           input logic er);
        #2;
        chk(name, en, fl, st, er);
    endtask

    initial begin
        // Stimulus runs as one continuous sequence; state carries row to row.
        //            ih    dh    da    mr    idrt   rs     rt     br    en        fl      st
        tbl[0]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'b11111, 3'b000, 2'd0);
        tbl[1]  = mk(1'b1, 1'b1, 1'b0, 1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 5'b00111, 3'b010, 2'd0);
        tbl[2]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd9, 5'd0, 1'b0, 5'b11111, 3'b000, 2'd0);
        tbl[3]  = mk(1'b1, 1'b1, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 5'b11111, 3'b000, 2'd0);
        tbl[4]  = mk(1'b1, 1'b1, 1'b0, 1'b1, 5'd9, 5'd3, 5'd9, 1'b0, 5'b00111, 3'b010, 2'd0);
        tbl[5]  = mk(1'b1, 1'b1, 1'b0, 1'b1, 5'd9, 5'd3, 5'd4, 1'b0, 5'b11111, 3'b000, 2'd0);
        tbl[6]  = mk(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'b00000, 3'b000, 2'd0);
        tbl[7]  = mk(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'b00000, 3'b000, 2'd1);
        tbl[8]  = mk(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'b00000, 3'b000, 2'd1);
        tbl[9]  = mk(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'b00000, 3'b000, 2'd1);
        tbl[10] = mk(1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'b11111, 3'b000, 2'd1);
        tbl[11] = mk(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'b11111, 3'b000, 2'd0);
        tbl[12] = mk(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'b01111, 3'b100, 2'd0);
        tbl[13] = mk(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'b11111, 3'b111, 2'd2);
        tbl[14] = mk(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'b01111, 3'b100, 2'd0);
        tbl[15] = mk(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'b11111, 3'b000, 2'd2);
        tbl[16] = mk(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'b11111, 3'b000, 2'd0);
        tbl[17] = mk(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'b00000, 3'b000, 2'd0);
        tbl[18] = mk(1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'b11111, 3'b111, 2'd1);
        tbl[19] = mk(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'b11111, 3'b000, 2'd0);
        tbl[20] = mk(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'b11111, 3'b111, 2'd0);
        tbl[21] = mk(1'b0, 1'b1, 1'b0, 1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 5'b01111, 3'b100, 2'd0);
        tbl[22] = mk(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'b11111, 3'b000, 2'd2);
        tbl[23] = mk(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'b11111, 3'b000, 2'd0);

        // Reset held: pipeline frozen.
        rstn = 1'b0;
        drive_normal();
        repeat (2) @(negedge clk);
        cyc_chk("reset_held", 5'b00000, 3'b000, 2'd0, 1'b0);
        @(negedge clk);
        rstn = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(tbl[i].ih, tbl[i].dh, tbl[i].da, tbl[i].mr,
                  tbl[i].idrt, tbl[i].rs, tbl[i].rt, tbl[i].br);
            cyc_chk($sformatf("vec%0d", i), tbl[i].en, tbl[i].fl, tbl[i].st, 1'b0);
        end

        // D-miss timeout (MISS_TIMEOUT=4): entry cycle, 4 cycles in DMISS, then ERR.
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        cyc_chk("dto_entry", 5'b00000, 3'b000, 2'd0, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            cyc_chk($sformatf("dto_wait%0d", k), 5'b00000, 3'b000, 2'd1, 1'b0);
        end
        @(negedge clk);
        cyc_chk("dto_err", 5'b00000, 3'b000, 2'd3, 1'b1);
        @(negedge clk);
        drive_normal();
        cyc_chk("err_sticky_hit", 5'b00000, 3'b000, 2'd3, 1'b1);
        @(negedge clk);
        cyc_chk("err_sticky_2", 5'b00000, 3'b000, 2'd3, 1'b1);
        @(negedge clk);
        rstn = 1'b0;
        cyc_chk("err_rst_low", 5'b00000, 3'b000, 2'd0, 1'b0);
        @(negedge clk);
        rstn = 1'b1;
        cyc_chk("err_cleared", 5'b11111, 3'b000, 2'd0, 1'b0);

        // I-miss timeout.
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        cyc_chk("ito_entry", 5'b01111, 3'b100, 2'd0, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            cyc_chk($sformatf("ito_wait%0d", k), 5'b01111, 3'b100, 2'd2, 1'b0);
        end
        @(negedge clk);
        cyc_chk("ito_err", 5'b00000, 3'b000, 2'd3, 1'b1);
        @(negedge clk);
        rstn = 1'b0;
        drive_normal();
        @(negedge clk);
        rstn = 1'b1;
        cyc_chk("ito_cleared", 5'b11111, 3'b000, 2'd0, 1'b0);

        // Reset mid-miss aborts immediately.
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        @(negedge clk);
        cyc_chk("midmiss_dmiss", 5'b00000, 3'b000, 2'd1, 1'b0);
        @(negedge clk);
        rstn = 1'b0;
        cyc_chk("midmiss_rst", 5'b00000, 3'b000, 2'd0, 1'b0);
        @(negedge clk);
        rstn = 1'b1;
        drive_normal();
        cyc_chk("midmiss_run", 5'b11111, 3'b000, 2'd0, 1'b0);
        @(negedge clk);
        cyc_chk("midmiss_run2", 5'b11111, 3'b000, 2'd0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
